// File: rtl/keypad_scanner_if.sv
// Key matrix and decoded-key signal bundle between the keypad scanner and its consumers.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] digits;

    modport master (
        input  row,
        output col, key_code, key_valid, key_held, digits
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_held, digits
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; optional 8-digit entry buffer
// enabled by defining KEYPAD_DIGIT_BUF_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 65536,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master bus
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       row_m, row_s;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [3:0]       col_q, col_nxt;
    logic [3:0]       cap_row, cap_row_nxt;
    logic [3:0]       key_code_q, key_code_nxt;
    logic             key_valid_q, key_valid_nxt;
    logic             key_held_q;
    logic             sample_c, one_low_c, row_idle_c;
    logic [3:0]       row_low_c;
    logic [1:0]       row_idx_c, col_idx_c;

    // Position of the (single) zero in a one-cold nibble.
    function automatic logic [1:0] low_pos(input logic [3:0] v);
        logic [1:0] p;
        p = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) p = 2'(i);
        end
        return p;
    endfunction

    // Row synchronizer and free-running scan divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_m   <= 4'hF;
            row_s   <= 4'hF;
            div_cnt <= '0;
        end else begin
            row_m   <= bus.row;
            row_s   <= row_m;
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign sample_c   = (div_cnt == DIV_LAST);
    assign row_low_c  = ~row_s;
    assign one_low_c  = (row_low_c != 4'd0) && ((row_low_c & (row_low_c - 4'd1)) == 4'd0);
    assign row_idle_c = (row_s == 4'hF);
    assign row_idx_c  = low_pos(cap_row);
    assign col_idx_c  = low_pos(col_q);

    always_ff @(posedge clk) begin
        if (rst) state <= S_SCAN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sample_c) begin
            case (state)
                S_SCAN:     if (one_low_c) state_nxt = S_DEBOUNCE;
                S_DEBOUNCE: if (row_s != cap_row)      state_nxt = S_SCAN;
                            else if (deb_cnt == DEB_LAST) state_nxt = S_HELD;
                S_HELD:     if (row_idle_c) state_nxt = S_RELEASE;
                S_RELEASE:  if (!row_idle_c)           state_nxt = S_HELD;
                            else if (deb_cnt == DEB_LAST) state_nxt = S_SCAN;
                default:    state_nxt = S_SCAN;
            endcase
        end
    end

    // Datapath next values; only sample points change anything but the pulse.
    always_comb begin
        deb_cnt_nxt   = deb_cnt;
        col_nxt       = col_q;
        cap_row_nxt   = cap_row;
        key_code_nxt  = key_code_q;
        key_valid_nxt = 1'b0;
        if (sample_c) begin
            case (state)
                S_SCAN: begin
                    if (one_low_c) begin
                        cap_row_nxt = row_s;
                        deb_cnt_nxt = DEB_W'(1);
                    end else begin
                        col_nxt = {col_q[2:0], col_q[3]};
                    end
                end
                S_DEBOUNCE: begin
                    if (row_s != cap_row) begin
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt_nxt   = '0;
                        key_code_nxt  = {row_idx_c, col_idx_c};
                        key_valid_nxt = 1'b1;
                    end else begin
                        deb_cnt_nxt = deb_cnt + DEB_W'(1);
                    end
                end
                S_HELD: begin
                    if (row_idle_c) deb_cnt_nxt = DEB_W'(1);
                end
                S_RELEASE: begin
                    if (!row_idle_c || deb_cnt == DEB_LAST) deb_cnt_nxt = '0;
                    else                                    deb_cnt_nxt = deb_cnt + DEB_W'(1);
                end
                default: deb_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt     <= '0;
            col_q       <= 4'b1110;
            cap_row     <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            deb_cnt     <= deb_cnt_nxt;
            col_q       <= col_nxt;
            cap_row     <= cap_row_nxt;
            key_code_q  <= key_code_nxt;
            key_valid_q <= key_valid_nxt;
            key_held_q  <= (state_nxt == S_HELD) || (state_nxt == S_RELEASE);
        end
    end

    assign bus.col       = col_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;

`ifdef KEYPAD_DIGIT_BUF_EN
    logic [31:0] digits_q;

    // Newest key enters dig0; dig7 falls off the top.
    always_ff @(posedge clk) begin
        if (rst)                digits_q <= 32'h0;
        else if (key_valid_nxt) digits_q <= {digits_q[27:0], key_code_nxt};
    end

    assign bus.digits = digits_q;
`else
    assign bus.digits = 32'h0;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed plus random keypad stimulus checked every cycle against a sample-level key model.
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pressed;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          guard;

    int          m_col, m_mode, m_run, m_n;
    logic [3:0]  m_pat, m_rm, m_rs, m_code;
    logic        m_valid;
    logic [31:0] m_digits;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] matrix(input logic [15:0] p, input int c);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++) begin
            if (p[ri*4 + c]) r[ri] = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_mode = M_SCAN; m_run = 0; m_n = 0;
        m_pat = 4'hF; m_rm = 4'hF; m_rs = 4'hF;
        m_code = 4'h0; m_valid = 1'b0; m_digits = 32'h0;
    endtask

    // One clock edge of the key model: decisions see rows delayed by two edges.
    task automatic model_edge(input logic [3:0] row_now);
        int lows;
        int ridx;
        if (rst) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        if ((m_n % SCAN_DIV) == SCAN_DIV - 1) begin
            lows = 4 - $countones(m_rs);
            if (m_mode == M_SCAN) begin
                if (lows == 1) begin
                    m_pat = m_rs; m_run = 1; m_mode = M_DEB;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (m_mode == M_DEB) begin
                if (m_rs != m_pat) begin
                    m_mode = M_SCAN;
                end else begin
                    m_run++;
                    if (m_run == DEB) begin
                        ridx = 0;
                        for (int i = 0; i < 4; i++) if (!m_pat[i]) ridx = i;
                        m_code  = 4'(ridx * 4 + m_col);
                        m_valid = 1'b1;
`ifdef KEYPAD_DIGIT_BUF_EN
                        m_digits = {m_digits[27:0], m_code};
`endif
                        m_mode = M_HELD;
                    end
                end
            end else if (m_mode == M_HELD) begin
                if (m_rs == 4'hF) begin
                    m_run = 1; m_mode = M_REL;
                end
            end else begin
                if (m_rs != 4'hF) begin
                    m_mode = M_HELD;
                end else begin
                    m_run++;
                    if (m_run == DEB) m_mode = M_SCAN;
                end
            end
        end
        m_n++;
        m_rs = m_rm;
        m_rm = row_now;
    endtask

    task automatic step(input int n);
        logic [3:0] ecol;
        for (int k = 0; k < n; k++) begin
            kif.row = matrix(pressed, m_col);
            @(posedge clk);
            model_edge(kif.row);
            #1;
            if (kif.key_valid === 1'b1) pulses++;
            ecol = 4'b0001 << m_col;
            ecol = ~ecol;
            chk("col", 32'(kif.col), 32'(ecol));
            chk("key_valid", 32'(kif.key_valid), 32'(m_valid));
            chk("key_code", 32'(kif.key_code), 32'(m_code));
            chk("key_held", 32'(kif.key_held), 32'((m_mode == M_HELD) || (m_mode == M_REL)));
            chk("digits", kif.digits, m_digits);
        end
    endtask

    task automatic wait_capture(input string tag);
        guard = 0;
        while (m_mode != M_DEB && guard < 64) begin
            step(1);
            guard++;
        end
        chk(tag, 32'(guard < 64), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_d;
        model_reset();
        pressed = 16'h0;
        kif.row = 4'hF;
        rst = 1'b1;
        step(3);
        chk("rst_col", 32'(kif.col), 32'h0000_000E);
        chk("rst_valid", 32'(kif.key_valid), 32'd0);
        chk("rst_held", 32'(kif.key_held), 32'd0);
        chk("rst_digits", kif.digits, 32'h0);
        rst = 1'b0;
        step(4); chk("rot1", 32'(kif.col), 32'h0000_000D);
        step(4); chk("rot2", 32'(kif.col), 32'h0000_000B);
        step(4); chk("rot3", 32'(kif.col), 32'h0000_0007);
        step(4); chk("rot4", 32'(kif.col), 32'h0000_000E);

        // Single press of row2/col1.
        pulses = 0;
        pressed = 16'h0001 << 9;
        step(40);
        chk("single_pulses", 32'(pulses), 32'd1);
        chk("single_code", 32'(kif.key_code), 32'h9);
        chk("single_held", 32'(kif.key_held), 32'd1);
`ifdef KEYPAD_DIGIT_BUF_EN
        exp_d = 32'h0000_0009;
`else
        exp_d = 32'h0;
`endif
        chk("single_digits", kif.digits, exp_d);
        pressed = 16'h0;
        step(40);
        chk("single_release", 32'(kif.key_held), 32'd0);

        // Glitch: released right after capture.
        pulses = 0;
        pressed = 16'h0001 << 9;
        wait_capture("glitch_capture_timeout");
        pressed = 16'h0;
        step(24);
        chk("glitch_pulses", 32'(pulses), 32'd0);

        // Two rows on the same column.
        pulses = 0;
        pressed = 16'h1001;
        step(40);
        chk("multi_pulses", 32'(pulses), 32'd0);
        chk("multi_held", 32'(kif.key_held), 32'd0);
        pressed = 16'h0;
        step(8);

        // Buffer shift of keys 1, 2, 3 from a clean start, with a release bounce on 3.
        rst = 1'b1; step(3); rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            pressed = 16'h0001 << k;
            step(40);
            if (k == 3) begin
                pulses = 0;
                pressed = 16'h0;
                step(8);
                pressed = 16'h0001 << 3;
                step(20);
                chk("bounce_pulses", 32'(pulses), 32'd0);
                chk("bounce_held", 32'(kif.key_held), 32'd1);
            end
            pressed = 16'h0;
            step(40);
        end
`ifdef KEYPAD_DIGIT_BUF_EN
        exp_d = 32'h0000_0123;
`else
        exp_d = 32'h0;
`endif
        chk("buf_digits", kif.digits, exp_d);
        chk("buf_code", 32'(kif.key_code), 32'h3);

        // Reset in the middle of debouncing.
        pulses = 0;
        pressed = 16'h0001 << 9;
        wait_capture("rstdeb_capture_timeout");
        step(2);
        rst = 1'b1;
        step(1);
        chk("rstdeb_col", 32'(kif.col), 32'h0000_000E);
        chk("rstdeb_valid", 32'(kif.key_valid), 32'd0);
        chk("rstdeb_digits", kif.digits, 32'h0);
        rst = 1'b0;
        pressed = 16'h0;
        step(24);
        chk("rstdeb_pulses", 32'(pulses), 32'd0);

        // Random key patterns and durations.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(3, 0))
                0:       pressed = 16'h0;
                1, 2:    pressed = 16'h0001 << $urandom_range(15, 0);
                default: pressed = 16'($urandom);
            endcase
            step(int'($urandom_range(48, 1)));
        end
        pressed = 16'h0;
        step(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
